pio_wr_arbiter: RTL and testbench
=================================

PIO_WR_ARBITER -- requirements
Module: pio_wr_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 1, sets the idle cycles forced after each PIO write (legal range 0..15).
REQ-002 Parameter CNT_W, default 16, sets the width of the completed-write counter.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0  input  1  requester 0 (CPU store path) write request; held until ack0.
REQ-006 data0  input  32  requester 0 write word {GPIOf0[21:0], LED[7:0], counter_set[1:0]}; stable while req0 high.
REQ-007 ack0  output  1  one-cycle completion pulse to requester 0.
REQ-008 req1  input  1  requester 1 (debug/DMA port) write request; held until ack1.
REQ-009 data1  input  32  requester 1 write word, same packing; stable while req1 high.
REQ-010 ack1  output  1  one-cycle completion pulse to requester 1.
REQ-011 pio_en  output  1  write enable to PIO port; PIO captures on falling edge inside the high cycle.
REQ-012 pio_data  output  32  word presented to PIO; valid whenever pio_en high.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 last_grant  output  1  index of the most recently served requester.
REQ-015 write_count  output  CNT_W  number of completed PIO writes, modulo 2^CNT_W.

Function
REQ-016 FSM states SHALL be IDLE, WRITE, GAP.
REQ-017 IDLE: with no request, remain in IDLE; with any request, latch winner index and winner data into a holding register and enter WRITE at the next edge.
REQ-018 Arbitration SHALL be two-way round-robin: a single requester wins; when both request, the requester != last_grant wins.
REQ-019 WRITE SHALL last exactly one cycle with pio_en=1, pio_data=holding register, and ack of the winner=1; the other ack stays 0.
REQ-020 Latency: request sampled at edge k -> pio_en and ack high for cycle k+1 -> write_count incremented and last_grant updated at edge k+2.
REQ-021 After WRITE, enter GAP for GAP_CYCLES cycles, then IDLE; GAP_CYCLES=0 returns directly to IDLE.
REQ-022 Requests are not sampled in WRITE or GAP; pending requests wait and are arbitrated in IDLE.
REQ-023 A requester SHALL drop req at the edge ending its ack cycle; req still high in IDLE is treated as a new request.
REQ-024 pio_data SHALL hold its last value outside WRITE; pio_en and both acks SHALL be 0 outside WRITE.
REQ-025 write_count SHALL wrap from all-ones to zero without flagging.
REQ-026 Changes on dataN while reqN is low, or after latching, SHALL not affect the word written.

Reset
REQ-027 rst SHALL force immediately: state=IDLE, pio_en=0, ack0=0, ack1=0, busy=0, pio_data=0, write_count=0, last_grant=1 (requester 0 wins first contention).
REQ-028 rst asserted during WRITE or GAP SHALL abort the transaction: no ack issued, write_count unchanged from reset value, held request re-arbitrated after release.
REQ-029 After rst deasserts, the first rising edge SHALL sample requests normally.

Structure
REQ-030 Shared package pio_arb_pkg SHALL hold the state enum, PIO word width (32), field widths (22/8/2) and field offsets.
REQ-031 Round-robin selection SHALL be a sub-module rr_arb2 (inputs req[1:0], last; outputs grant valid and index).
REQ-032 Holding register, FSM, GAP counter and write counter SHALL reside in pio_wr_arbiter.

Verification
REQ-033 req0 only, data0=32'h0000_02A5, GAP=1 -> pio_en high one cycle with pio_data=32'h0000_02A5, ack0 same cycle, write_count=1, last_grant=0.
REQ-034 req0 and req1 raised same edge after reset, data0=32'h11, data1=32'h22 -> writes 32'h11 then 32'h22, ack0 before ack1, separated by GAP_CYCLES idle cycles.
REQ-035 Both held for four writes -> grants alternate 0,1,0,1; write_count=4.
REQ-036 GAP_CYCLES=0, req1 held continuously with changing data -> back-to-back writes every 2 cycles, each with the data present at its IDLE sampling edge.
REQ-037 rst pulsed during WRITE cycle -> pio_en and ack fall immediately, write_count=0, request served again after release.
REQ-038 CNT_W=4, 17 writes -> write_count wraps 15->0 and reads 1.

Source files
------------

// File: rtl/pio_arb_pkg.sv
// Shared types and PIO word layout for the PIO write arbiter.
package pio_arb_pkg;

    // PIO word layout, LSB first: {gpio[21:0], led[7:0], counter_set[1:0]}
    localparam int unsigned CsetW   = 2;
    localparam int unsigned LedW    = 8;
    localparam int unsigned GpioW   = 22;
    localparam int unsigned CsetLsb = 0;
    localparam int unsigned LedLsb  = CsetLsb + CsetW;
    localparam int unsigned GpioLsb = LedLsb + LedW;
    localparam int unsigned PioW    = GpioLsb + GpioW;

    // Width of the post-write gap counter (GAP_CYCLES is 0..15)
    localparam int unsigned GapW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StGap
    } arb_state_t;

    // Assemble a PIO word from its fields
    function automatic logic [PioW-1:0] pio_pack(input logic [GpioW-1:0] gpio,
                                                 input logic [LedW-1:0]  led,
                                                 input logic [CsetW-1:0] cset);
        return {gpio, led, cset};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: a lone requester wins, on contention the
// requester that was not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       idx
);

    // Combinational grant decision
    always_comb begin
        valid = |req;
        idx   = 1'b0;
        if (&req) begin
            idx = ~last;
        end else begin
            idx = req[1];
        end
    end

endmodule

// File: rtl/pio_wr_arbiter.sv
// Arbitrates two write requesters onto a single PIO write port. Each write
// is a one-cycle WRITE followed by GAP_CYCLES forced idle cycles.
module pio_wr_arbiter
    import pio_arb_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [PioW-1:0]  data0,
    output logic             ack0,
    input  logic             req1,
    input  logic [PioW-1:0]  data1,
    output logic             ack1,
    output logic             pio_en,
    output logic [PioW-1:0]  pio_data,
    output logic             busy,
    output logic             last_grant,
    output logic [CNT_W-1:0] write_count
);

    // Gap counter load value; counts down to zero inclusive
    localparam int unsigned     GapLastI = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
    localparam logic [GapW-1:0] GapLast  = GapW'(GapLastI);

    arb_state_t      state;
    logic [GapW-1:0] gap_cnt;
    logic            win_idx;
    logic            grant_valid;
    logic            grant_idx;

    rr_arb2 u_rr_arb2 (
        .req   ({req1, req0}),
        .last  (last_grant),
        .valid (grant_valid),
        .idx   (grant_idx)
    );

    assign busy = (state != StIdle);

    // FSM with registered outputs; pio_data doubles as the holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            gap_cnt     <= '0;
            win_idx     <= 1'b0;
            pio_en      <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            pio_data    <= '0;
            write_count <= '0;
            last_grant  <= 1'b1;
        end else begin
            unique case (state)
                StIdle: begin
                    if (grant_valid) begin
                        win_idx  <= grant_idx;
                        pio_data <= grant_idx ? data1 : data0;
                        pio_en   <= 1'b1;
                        ack0     <= ~grant_idx;
                        ack1     <= grant_idx;
                        state    <= StWrite;
                    end
                end
                StWrite: begin
                    pio_en      <= 1'b0;
                    ack0        <= 1'b0;
                    ack1        <= 1'b0;
                    write_count <= write_count + 1'b1;
                    last_grant  <= win_idx;
                    if (GAP_CYCLES == 0) begin
                        state <= StIdle;
                    end else begin
                        gap_cnt <= GapLast;
                        state   <= StGap;
                    end
                end
                StGap: begin
                    if (gap_cnt == '0) begin
                        state <= StIdle;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pio_wr_arbiter.sv
// Scoreboard bench for pio_wr_arbiter: instance A (GAP_CYCLES=1, CNT_W=16)
// and instance B (GAP_CYCLES=0, CNT_W=4).
module tb_pio_wr_arbiter;
    import pio_arb_pkg::*;

    typedef struct {
        bit          idx;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    exp_t qa[$];
    exp_t qb[$];

    // Instance A signals
    logic        rst_a, req0_a, req1_a, ack0_a, ack1_a, pio_en_a, busy_a, last_a;
    logic [31:0] data0_a, data1_a, pio_data_a;
    logic [15:0] cnt_a;

    // Instance B signals
    logic        rst_b, req0_b, req1_b, ack0_b, ack1_b, pio_en_b, busy_b, last_b;
    logic [31:0] data0_b, data1_b, pio_data_b;
    logic [3:0]  cnt_b;
    int          exp_cnt_b = 0;

    pio_wr_arbiter #(.GAP_CYCLES(1), .CNT_W(16)) dut_a (
        .clk (clk), .rst (rst_a),
        .req0 (req0_a), .data0 (data0_a), .ack0 (ack0_a),
        .req1 (req1_a), .data1 (data1_a), .ack1 (ack1_a),
        .pio_en (pio_en_a), .pio_data (pio_data_a), .busy (busy_a),
        .last_grant (last_a), .write_count (cnt_a)
    );

    pio_wr_arbiter #(.GAP_CYCLES(0), .CNT_W(4)) dut_b (
        .clk (clk), .rst (rst_b),
        .req0 (req0_b), .data0 (data0_b), .ack0 (ack0_b),
        .req1 (req1_b), .data1 (data1_b), .ack1 (ack1_b),
        .pio_en (pio_en_b), .pio_data (pio_data_b), .busy (busy_b),
        .last_grant (last_b), .write_count (cnt_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor A: every PIO write must match the next scoreboard entry
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (pio_en_a) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_write", pio_data_a, 32'hxxxx_xxxx);
            end else begin
                e = qa.pop_front();
                chk("a_pio_data", pio_data_a, e.data);
                chk("a_ack0", 32'(ack0_a), 32'(!e.idx));
                chk("a_ack1", 32'(ack1_a), 32'(e.idx));
            end
        end else if (ack0_a || ack1_a) begin
            chk("a_ack_without_en", 32'({ack1_a, ack0_a}), 32'd0);
        end
    end

    // Monitor B
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (pio_en_b) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_write", pio_data_b, 32'hxxxx_xxxx);
            end else begin
                e = qb.pop_front();
                chk("b_pio_data", pio_data_b, e.data);
                chk("b_ack0", 32'(ack0_b), 32'(!e.idx));
                chk("b_ack1", 32'(ack1_b), 32'(e.idx));
            end
        end else if (ack0_b || ack1_b) begin
            chk("b_ack_without_en", 32'({ack1_b, ack0_b}), 32'd0);
        end
    end

    // Requester on A: raise, hold until ack, drop at the edge ending the ack cycle
    task automatic a_req(input bit p, input logic [31:0] d, output int ackc);
        logic got;
        got  = 1'b0;
        ackc = -1;
        qa.push_back('{idx: p, data: d});
        if (p) begin req1_a = 1'b1; data1_a = d; end
        else   begin req0_a = 1'b1; data0_a = d; end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (p ? ack1_a : ack0_a) begin
                got  = 1'b1;
                ackc = cyc;
                break;
            end
        end
        if (!got) chk(p ? "a_ack1_timeout" : "a_ack0_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        // Scramble data after release; must not reach the PIO port
        if (p) begin req1_a = 1'b0; data1_a = ~d; end
        else   begin req0_a = 1'b0; data0_a = ~d; end
    endtask

    task automatic a_wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy_a) break;
        end
        chk("a_idle", 32'(busy_a), 32'd0);
    endtask

    task automatic a_reset();
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
    endtask

    // B burst with GAP_CYCLES=0: request held through WRITE, data junked while
    // in WRITE; a write must appear every second cycle
    task automatic b_burst(input bit p, input int n, input logic [31:0] base);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            d = base + 32'(i);
            qb.push_back('{idx: p, data: d});
            if (p) begin req1_b = 1'b1; data1_b = d; end
            else   begin req0_b = 1'b1; data0_b = d; end
            @(negedge clk);
            chk("b_write_cycle", 32'(pio_en_b), 32'd1);
            if (p) begin data1_b = ~d; if (i == n - 1) req1_b = 1'b0; end
            else   begin data0_b = ~d; if (i == n - 1) req0_b = 1'b0; end
            @(negedge clk);
            exp_cnt_b++;
            chk("b_idle_cycle", 32'(pio_en_b), 32'd0);
            chk("b_count", 32'(cnt_b), 32'(exp_cnt_b % 16));
            chk("b_last_grant", 32'(last_b), 32'(p));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c0, c1, x0, x1;
        rst_a = 1'b1; req0_a = 1'b0; req1_a = 1'b0; data0_a = '0; data1_a = '0;
        rst_b = 1'b1; req0_b = 1'b0; req1_b = 1'b0; data0_b = '0; data1_b = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_pio_en", 32'(pio_en_a), 32'd0);
        chk("rst_acks", 32'({ack1_a, ack0_a}), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_pio_data", pio_data_a, 32'd0);
        chk("rst_count", 32'(cnt_a), 32'd0);
        chk("rst_last_grant", 32'(last_a), 32'd1);
        chk("rst_b_last_grant", 32'(last_b), 32'd1);
        chk("rst_b_count", 32'(cnt_b), 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);

        // Single write from requester 0: ack one cycle after sampling
        c = cyc;
        a_req(1'b0, pio_pack(22'h0, 8'hA9, 2'h1), c0);
        chk("single_latency", 32'(c0 - c), 32'd1);
        a_wait_idle();
        chk("single_count", 32'(cnt_a), 32'd1);
        chk("single_last_grant", 32'(last_a), 32'd0);
        chk("single_hold", pio_data_a, 32'h0000_02A5);

        // Simultaneous requests after reset: 0 first, then 1 after the gap
        a_reset();
        c = cyc;
        fork
            a_req(1'b0, 32'h11, c0);
            a_req(1'b1, 32'h22, c1);
        join
        chk("contend_first_latency", 32'(c0 - c), 32'd1);
        chk("contend_spacing", 32'(c1 - c0), 32'd3);
        a_wait_idle();
        chk("contend_count", 32'(cnt_a), 32'd2);
        chk("contend_last_grant", 32'(last_a), 32'd1);

        // Both requesters keep requesting: grants alternate 0,1,0,1
        a_reset();
        fork
            begin
                a_req(1'b0, 32'hA000_0001, x0);
                @(negedge clk);
                a_req(1'b0, 32'hA000_0002, x0);
            end
            begin
                a_req(1'b1, 32'hB000_0001, x1);
                @(negedge clk);
                a_req(1'b1, 32'hB000_0002, x1);
            end
        join
        a_wait_idle();
        chk("rr_count", 32'(cnt_a), 32'd4);
        chk("rr_last_grant", 32'(last_a), 32'd1);

        // Reset in the WRITE cycle aborts; the held request is served again
        a_reset();
        req0_a  = 1'b1;
        data0_a = 32'h0000_0055;
        qa.push_back('{idx: 1'b0, data: 32'h0000_0055});
        qa.push_back('{idx: 1'b0, data: 32'h0000_0055});
        @(negedge clk);
        chk("abort_in_write", 32'(pio_en_a), 32'd1);
        #1;
        rst_a = 1'b1;
        #1;
        chk("abort_pio_en", 32'(pio_en_a), 32'd0);
        chk("abort_ack0", 32'(ack0_a), 32'd0);
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_count", 32'(cnt_a), 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        c0 = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack0_a) begin c0 = i; break; end
        end
        chk("abort_reserved", 32'(c0), 32'd0);
        @(posedge clk);
        #1;
        req0_a = 1'b0;
        a_wait_idle();
        chk("abort_count_after", 32'(cnt_a), 32'd1);

        // B: GAP_CYCLES=0, continuous req1 with changing data, then wrap
        b_burst(1'b1, 5, 32'hC000_0100);
        b_burst(1'b0, 12, 32'hD000_0200);
        chk("wrap_count", 32'(cnt_b), 32'd1);

        repeat (2) @(negedge clk);
        chk("a_queue_empty", 32'(qa.size()), 32'd0);
        chk("b_queue_empty", 32'(qb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
